// File: rtl/matmult_stream_if_pkg.sv
// Shared types and constants for the 2x2 matrix multiplier stream interface.
// Included by matmult_stream_if and mod_counter.
package matmult_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int NUM_OPERANDS = 8;
    localparam int NUM_RESULTS  = 4;
    localparam int CNT_W        = 8;

    localparam int A11_IDX = 0;
    localparam int A12_IDX = 1;
    localparam int A21_IDX = 2;
    localparam int A22_IDX = 3;
    localparam int B11_IDX = 4;
    localparam int B12_IDX = 5;
    localparam int B21_IDX = 6;
    localparam int B22_IDX = 7;

    // Last count value of each state; the single shared counter wraps on it.
    function automatic logic [CNT_W-1:0] term_for_state(input state_e s, input int calc_cycles);
        logic [CNT_W-1:0] t;
        t = '0;
        case (s)
            LOAD:    t = CNT_W'(NUM_OPERANDS - 1);
            WAIT:    t = CNT_W'(calc_cycles - 1);
            DRAIN:   t = CNT_W'(NUM_RESULTS - 1);
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/matmult_stream_if_mod_counter.sv
// Modulo counter with enable, synchronous clear and a runtime terminal value.
// Wraps to zero on an enabled cycle at the terminal value; tc flags that value.
module mod_counter
    import matmult_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    assign tc  = (cnt_q == term);
    assign cnt = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/matmult_stream_if.sv
// Stream front/back end for the 2x2 matrix multiplier: loads 8 operands, waits
// CALC_CYCLES, captures 4 results and drains them. Optional MATMULT_STREAM_ERR_EN adds framing check.
module matmult_stream_if
    import matmult_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CALC_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef MATMULT_STREAM_ERR_EN
    input  logic             in_last,
    output logic             err,
`endif
    output logic [WIDTH-1:0] a11,
    output logic [WIDTH-1:0] a12,
    output logic [WIDTH-1:0] a21,
    output logic [WIDTH-1:0] a22,
    output logic [WIDTH-1:0] b11,
    output logic [WIDTH-1:0] b12,
    output logic [WIDTH-1:0] b21,
    output logic [WIDTH-1:0] b22,
    input  logic [WIDTH-1:0] c11,
    input  logic [WIDTH-1:0] c12,
    input  logic [WIDTH-1:0] c21,
    input  logic [WIDTH-1:0] c22,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_tc;
    logic             cnt_en;
    logic             in_hs;
    logic             out_hs;
    logic             capture;

    logic [WIDTH-1:0] op_q  [NUM_OPERANDS];
    logic [WIDTH-1:0] res_q [NUM_RESULTS];
    logic [WIDTH-1:0] c_in  [NUM_RESULTS];

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == WAIT) || (state_q == DRAIN);
    assign out_last  = out_valid && cnt_tc;

    assign in_hs   = in_ready && in_valid;
    assign out_hs  = out_valid && out_ready;
    assign capture = (state_q == WAIT) && cnt_tc;

    assign cnt_term = term_for_state(state_q, CALC_CYCLES);

    always_comb begin
        cnt_en = 1'b0;
        case (state_q)
            LOAD:    cnt_en = in_valid;
            WAIT:    cnt_en = 1'b1;
            DRAIN:   cnt_en = out_ready;
            default: cnt_en = 1'b0;
        endcase
    end

    // One counter serves all three phases; each phase ends exactly when it wraps.
    mod_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (1'b0),
        .term  (cnt_term),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            case (state_q)
                LOAD:    if (in_hs && cnt_tc)  state_q <= WAIT;
                WAIT:    if (cnt_tc)           state_q <= DRAIN;
                DRAIN:   if (out_hs && cnt_tc) state_q <= LOAD;
                default: state_q <= LOAD;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_op
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    op_q[gi] <= '0;
                end else if (in_hs && (cnt == CNT_W'(gi))) begin
                    op_q[gi] <= in_data;
                end
            end
        end
    endgenerate

    assign c_in[0] = c11;
    assign c_in[1] = c12;
    assign c_in[2] = c21;
    assign c_in[3] = c22;

    // Results are held locally so the multiplier may move on while draining.
    generate
        for (genvar gi = 0; gi < NUM_RESULTS; gi++) begin : g_res
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    res_q[gi] <= '0;
                end else if (capture) begin
                    res_q[gi] <= c_in[gi];
                end
            end
        end
    endgenerate

    assign out_data = out_valid ? res_q[cnt[1:0]] : '0;

    assign a11 = op_q[A11_IDX];
    assign a12 = op_q[A12_IDX];
    assign a21 = op_q[A21_IDX];
    assign a22 = op_q[A22_IDX];
    assign b11 = op_q[B11_IDX];
    assign b12 = op_q[B12_IDX];
    assign b21 = op_q[B21_IDX];
    assign b22 = op_q[B22_IDX];

`ifdef MATMULT_STREAM_ERR_EN
    logic err_q;

    // Sticky framing error: in_last must be high on the eighth word only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (in_hs && (in_last != cnt_tc)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_matmult_stream_if.sv
// Randomised self-checking bench for matmult_stream_if against a matrix-product model.
// Exercises MATMULT_STREAM_ERR_EN framing checks when that macro is defined.
module tb_matmult_stream_if;

    localparam int WIDTH = 32;
    localparam int CALC  = 4;

    typedef logic [7:0][31:0] w8_t;
    typedef logic [3:0][31:0] w4_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_last = 1'b0;
    logic             err;
    logic [WIDTH-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
    logic [WIDTH-1:0] c11, c12, c21, c22;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic err_exp = 1'b0;

    logic [31:0] junk_q = 32'h0;
    logic [31:0] ops [8];

    matmult_stream_if #(
        .WIDTH       (WIDTH),
        .CALC_CYCLES (CALC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MATMULT_STREAM_ERR_EN
        .in_last   (in_last),
        .err       (err),
`endif
        .a11 (a11), .a12 (a12), .a21 (a21), .a22 (a22),
        .b11 (b11), .b12 (b12), .b21 (b21), .b22 (b22),
        .c11 (c11), .c12 (c12), .c21 (c21), .c22 (c22),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

`ifndef MATMULT_STREAM_ERR_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) junk_q <= $urandom;

    always_comb begin
        ops[0] = a11; ops[1] = a12; ops[2] = a21; ops[3] = a22;
        ops[4] = b11; ops[5] = b12; ops[6] = b21; ops[7] = b22;
    end

    // Environment multiplier: true products only while computing, noise otherwise.
    always_comb begin
        if (busy && !out_valid) begin
            c11 = a11 * b11 + a12 * b21;
            c12 = a11 * b12 + a12 * b22;
            c21 = a21 * b11 + a22 * b21;
            c22 = a21 * b12 + a22 * b22;
        end else begin
            c11 = junk_q;
            c12 = ~junk_q;
            c21 = junk_q ^ 32'h5a5a_5a5a;
            c22 = junk_q + 32'd7;
        end
    end

    function automatic w4_t ref_mult(input w8_t m);
        w4_t r;
        // m = {a11,a12,a21,a22,b11,b12,b21,b22} in index order 0..7
        r[0] = m[0] * m[4] + m[1] * m[6];
        r[1] = m[0] * m[5] + m[1] * m[7];
        r[2] = m[2] * m[4] + m[3] * m[6];
        r[3] = m[2] * m[5] + m[3] * m[7];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic load_matrix(input w8_t m, input int gap_pct, input int bad_idx);
        int i = 0;
        int guard = 0;
        logic hs;
        while (i < 8 && guard < 400) begin
            @(negedge clk);
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? m[i] : $urandom;
            in_last  = (i == 7) ^ (i == bad_idx);
            check("in_ready_load", {31'd0, in_ready}, 32'd1);
            check("busy_load", {31'd0, busy}, 32'd0);
            check("err_load", {31'd0, err}, {31'd0, err_exp});
            hs = in_valid;
            @(posedge clk);
            if (hs) begin
`ifdef MATMULT_STREAM_ERR_EN
                if (in_last != (i == 7)) err_exp = 1'b1;
`endif
                i++;
            end
            guard++;
        end
        if (i < 8) check("load_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the 8th handshake edge; ends at the negedge where out_valid rises.
    task automatic check_latency(input w8_t m);
        for (int k = 0; k <= CALC; k++) begin
            @(negedge clk);
            check("busy_wait", {31'd0, busy}, 32'd1);
            check("in_ready_wait", {31'd0, in_ready}, 32'd0);
            check("out_valid_lat", {31'd0, out_valid}, (k == CALC) ? 32'd1 : 32'd0);
            for (int o = 0; o < 8; o++) check($sformatf("operand%0d", o), ops[o], m[o]);
            if (k < CALC) @(posedge clk);
        end
    endtask

    task automatic drain(input w4_t exp, input int stall_idx, input int stall_n,
                         input int rnd_pct, input int stop_after);
        int j = 0;
        int stalled = 0;
        int guard = 0;
        logic rdy;
        while (j < 4 && guard < 400) begin
            check("out_valid_drain", {31'd0, out_valid}, 32'd1);
            check("in_ready_drain", {31'd0, in_ready}, 32'd0);
            check($sformatf("out_data_w%0d", j), out_data, exp[j]);
            check("out_last", {31'd0, out_last}, (j == 3) ? 32'd1 : 32'd0);
            check("err_drain", {31'd0, err}, {31'd0, err_exp});
            if (j == stall_idx && stalled < stall_n) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = ($urandom_range(99) >= rnd_pct);
            end
            out_ready = rdy;
            @(posedge clk);
            if (rdy) begin
                $display("drain word %0d = %0d last=%0d", j, exp[j], (j == 3));
                j++;
            end
            guard++;
            if (j == stop_after) break;
            @(negedge clk);
        end
        if (j < 4 && j != stop_after) check("drain_timeout", 32'd0, 32'd1);
        #1;
        out_ready = 1'b0;
        if (j == 4) begin
            @(negedge clk);
            check("in_ready_after", {31'd0, in_ready}, 32'd1);
            check("out_valid_after", {31'd0, out_valid}, 32'd0);
            check("busy_after", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic run_matrix(input w8_t m, input int gap_pct, input int stall_idx,
                              input int stall_n, input int rnd_pct);
        w4_t r;
        r = ref_mult(m);
        load_matrix(m, gap_pct, -1);
        check_latency(m);
        drain(r, stall_idx, stall_n, rnd_pct, -1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        for (int o = 0; o < 8; o++) check($sformatf("%s_op%0d", tag, o), ops[o], 32'd0);
    endtask

    w8_t m_base, m_ident, m_rand;
    w4_t r_base;

    initial begin
        m_base  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        m_ident = {32'd8, 32'd7, 32'd6, 32'd5, 32'd1, 32'd0, 32'd0, 32'd1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_idle("idle");
            check("err_idle", {31'd0, err}, 32'd0);
        end

        // Known product, out_ready held high.
        run_matrix(m_base, 0, -1, 0, 0);

        // Gapped load and three-cycle stall on word 2.
        run_matrix(m_base, 40, 1, 3, 0);

        // Back-to-back: random matrix then identity A with B=[[5,6],[7,8]].
        for (int o = 0; o < 8; o++) m_rand[o] = $urandom;
        run_matrix(m_rand, 0, -1, 0, 0);
        run_matrix(m_ident, 0, -1, 0, 0);

        // Random operands, gaps and backpressure.
        for (int t = 0; t < 6; t++) begin
            for (int o = 0; o < 8; o++) m_rand[o] = (t < 3) ? $urandom_range(1000) : $urandom;
            run_matrix(m_rand, $urandom_range(60), -1, 0, $urandom_range(60));
        end

        // Reset in the middle of a drain, after word 1.
        r_base = ref_mult(m_base);
        load_matrix(m_base, 0, -1);
        check_latency(m_base);
        drain(r_base, -1, 0, 0, 1);
        @(negedge clk);
        reset = 1'b1;
        err_exp = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("post_reset");
        run_matrix(m_base, 20, -1, 0, 20);

`ifdef MATMULT_STREAM_ERR_EN
        // Framing error on word 5 must stick through the drain until reset.
        load_matrix(m_base, 0, 4);
        check("err_model_set", {31'd0, err_exp}, 32'd1);
        check_latency(m_base);
        drain(r_base, -1, 0, 0, -1);
        check("err_sticky", {31'd0, err}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        err_exp = 1'b0;
        #1;
        check("err_cleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_matrix(m_base, 0, -1, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matmult_stream_if.md
# matmult_stream_if

Stream front/back end for the 2x2 Strassen matrix multiplier. It accepts eight operand words over a valid/ready input stream and presents them as stable parallel operands a11..b22. It waits a fixed compute latency, captures the four parallel results c11..c22, and drains them over a valid/ready output stream with a last flag. It sits between the system bus adapter and the multiplier core.

## Interface
- WIDTH, 32: operand and result word width.
- CALC_CYCLES, 4: cycles from the operands becoming stable to the results being valid at c11..c22. Legal range is 1..255.
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_data, input, WIDTH: operand word.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block accepts in_data this cycle.
- a11, a12, a21, a22, b11, b12, b21, b22, output, WIDTH each: registered operands to the multiplier.
- c11, c12, c21, c22, input, WIDTH each: multiplier results.
- out_data, output, WIDTH: result word.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts out_data.
- out_last, output, 1: high with c22, the fourth result word.
- busy, output, 1: high in WAIT and DRAIN.
- in_last, input, 1: present only with MATMULT_STREAM_ERR_EN.
- err, output, 1: present only with MATMULT_STREAM_ERR_EN.

## Operation
- States:
  - LOAD: in_ready=1. An input handshake (in_valid&in_ready) writes in_data to the operand selected by cnt, in the order a11, a12, a21, a22, b11, b12, b21, b22, then increments cnt. The handshake at cnt=7 goes to WAIT with cnt=0.
  - WAIT: in_ready=0. cnt counts 0..CALC_CYCLES-1. In the cycle where cnt=CALC_CYCLES-1, c11..c22 are captured into internal result registers r0..r3 and the state goes to DRAIN with cnt=0.
  - DRAIN: out_valid=1 and out_data=r[cnt]. An output handshake (out_valid&out_ready) increments cnt. out_last=(cnt==3). The handshake at cnt=3 goes to LOAD with cnt=0.
- Operand registers change only on input handshakes. They stay stable through WAIT and DRAIN, and each one is overwritten in place during the next LOAD.
- The result registers decouple the drain from the multiplier. The multiplier outputs may change after capture without affecting out_data.
- No arithmetic is done here. Words pass through unmodified at WIDTH bits.
- reset mid-operation: the block abandons the current matrix, returns to LOAD with cnt=0, and zeroes the operand and result registers. Any partial drain is lost.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0, all operand outputs 0, err=0.
- in_ready, out_valid, out_last and busy decode combinationally from the registered state and cnt. There are no combinational paths from in_valid or out_ready to any output.
- The 8th input handshake at edge N:
  - busy=1 from N.
  - The result capture happens at edge N+CALC_CYCLES.
  - out_valid=1 from N+CALC_CYCLES.
- Best case the first out_data handshake is at edge N+CALC_CYCLES+1 and the last at edge N+CALC_CYCLES+4. in_ready=1 in the cycle following the last handshake.
- Throughput is one word per cycle on each stream. The two streams are never active in the same cycle.
- Stalls:
  - in_valid=0 in LOAD holds cnt.
  - out_ready=0 in DRAIN holds cnt and out_data stable. out_valid must not drop until the handshake.

## Configuration
- MATMULT_STREAM_ERR_EN defined:
  - Adds the in_last input and a sticky err output.
  - err is set when an input handshake has in_last=1 at cnt≠7, or in_last=0 at cnt=7.
  - Loading continues normally regardless of err. err is cleared only by reset.
- Undefined: neither port exists and framing is by word count only.

## Structure
- Shared package matmult_pkg holds:
  - the state enum (LOAD, WAIT, DRAIN);
  - NUM_OPERANDS=8 and NUM_RESULTS=4;
  - the operand index constants (A11_IDX=0 .. B22_IDX=7).
- Submodule mod_counter: a parameterised modulo counter with enable, clear and terminal-count output. It is instantiated once and shared across states, because its terminal value is selected per state (7, CALC_CYCLES-1, 3).

## Test plan
- Reset, no traffic: in_ready=1, out_valid=0, busy=0, all operands=0 for 20 cycles.
- With the real multiplier and CALC_CYCLES equal to its latency, stream 1,2,3,4,5,6,7,8 then hold out_ready=1: expect out_data 19, 22, 43, 50, out_last only on 50, and first out_valid exactly CALC_CYCLES cycles after the 8th handshake.
- Random in_valid gaps during load and out_ready=0 for 3 cycles on word 2: the operand sequence is unchanged, out_data holds 22 throughout the stall, and no word is duplicated or dropped.
- Two back-to-back matrices, the second being identity A with B=[[5,6],[7,8]]: the second drain is 5, 6, 7, 8, and in_ready rises the cycle after the first out_last handshake.
- reset asserted during DRAIN after word 1: the next cycle is LOAD with out_valid=0 and all registers zero, and the following matrix drains correctly.
- With MATMULT_STREAM_ERR_EN, in_last=1 on word 5: err rises after that edge and stays high through the full drain until reset.
